// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_reg
// Purpose  : MEM/WB pipeline register and writeback stage. It holds loads until
//            the SRAM returns data, then extends the loaded value and writes it
//            to the register file. Optional decode bypass via MEM_WB_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_reg #(
    parameter int MEM_WB_DATA = 46
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_to_wb_reg_valid,
    output logic                   mem_wb_reg_allow_in,
    input  logic [MEM_WB_DATA-1:0] mem_data,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   data_sram_rvalid,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [31:0]            rf_wdata,
`ifdef MEM_WB_FWD_EN
    output logic                   fwd_valid,
    output logic                   fwd_pending,
    output logic [4:0]             fwd_rd,
    output logic [31:0]            fwd_data,
`endif
    output logic [31:0]            wb_retire_cnt
);

    localparam logic [3:0] C_MEMTOREG_LOAD = 4'b0010;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [MEM_WB_DATA-1:0] r_payload;
    logic [31:0]            r_retire_cnt;

    logic                   w_regwrite;
    logic [3:0]             w_memtoreg;
    logic [2:0]             w_mem_mode;
    logic                   w_read_us;
    logic [4:0]             w_rd;
    logic [31:0]            w_result;
    logic                   w_is_load;
    logic                   w_in_is_load;
    logic                   w_ready_go;
    logic                   w_allow_in;
    logic                   w_accept;
    logic [1:0]             w_off;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [31:0]            w_load_data;

    assign w_regwrite = r_payload[45];
    assign w_memtoreg = r_payload[44:41];
    assign w_mem_mode = r_payload[40:38];
    assign w_read_us  = r_payload[37];
    assign w_rd       = r_payload[36:32];
    assign w_result   = r_payload[31:0];

    assign w_is_load    = (w_memtoreg == C_MEMTOREG_LOAD);
    assign w_in_is_load = (mem_data[44:41] == C_MEMTOREG_LOAD);

    assign w_ready_go = (r_state == S_READY) ||
                        ((r_state == S_WAIT) && data_sram_rvalid);
    assign w_allow_in = (r_state == S_EMPTY) || w_ready_go;
    assign w_accept   = w_allow_in && mem_to_wb_reg_valid;

    // A commit and a new accept may share an edge; the accept takes priority.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_in_is_load ? S_WAIT : S_READY;
        end else if (w_ready_go) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_payload <= '0;
        end else if (w_accept) begin
            r_payload <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire_cnt <= '0;
        end else if (w_ready_go) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    // Read data is used unbuffered in the rvalid cycle.
    assign w_off  = w_result[1:0];
    assign w_byte = data_sram_rdata[8*w_off +: 8];
    assign w_half = data_sram_rdata[16*w_off[1] +: 16];

    always_comb begin
        w_load_data = data_sram_rdata;
        case (w_mem_mode)
            3'b000:  w_load_data = w_read_us ? {24'd0, w_byte}
                                             : {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = w_read_us ? {16'd0, w_half}
                                             : {{16{w_half[15]}}, w_half};
            default: w_load_data = data_sram_rdata;
        endcase
    end

    assign mem_wb_reg_allow_in = w_allow_in;
    assign rf_we               = w_ready_go && w_regwrite && (w_rd != 5'd0);
    assign rf_waddr            = w_rd;
    assign rf_wdata            = w_is_load ? w_load_data : w_result;
    assign wb_retire_cnt       = r_retire_cnt;

`ifdef MEM_WB_FWD_EN
    assign fwd_valid   = (r_state != S_EMPTY) && w_regwrite && (w_rd != 5'd0);
    assign fwd_pending = (r_state == S_WAIT) && !data_sram_rvalid;
    assign fwd_rd      = w_rd;
    assign fwd_data    = rf_wdata;
`endif

endmodule
`default_nettype wire
